// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit two's-complement subtractor: one bit per clock with a registered borrow.
// Optional macro SERIAL_SUB_ADD_EN adds an 'add' port that selects a + b instead of a - b.
module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_SUB_ADD_EN
    input  logic             add,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             a_msb;
    logic             b_msb;
    logic             ai;
    logic             bi;
    logic             d;
    logic             ovf_next;
    logic             last;
`ifdef SERIAL_SUB_ADD_EN
    logic             add_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Full-subtractor (or full-adder) cell on the current LSBs; the last bit processed is the result MSB.
    always_comb begin
        ai       = a_sh[0];
        bi       = b_sh[0];
        d        = ai ^ bi ^ br;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br);
        ovf_next = (a_msb != b_msb) && (d != a_msb);
`ifdef SERIAL_SUB_ADD_EN
        if (add_r) begin
            br_next  = (ai & bi) | ((ai ^ bi) & br);
            ovf_next = (a_msb == b_msb) && (d != a_msb);
        end
`endif
        res_next = {d, res[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
            add_r    <= 1'b0;
`endif
            diff     <= '0;
            borrow   <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`ifdef SERIAL_SUB_ADD_EN
            add_r <= add;
`endif
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_next;
            br   <= br_next;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff     <= res_next;
                borrow   <= br_next;
                zero     <= (res_next == '0);
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=64), with hand-written sequences
// for ignored start, back-to-back operation and mid-run reset.
module tb_serial_subtractor;

    localparam int W = 64;

    typedef struct {
        string       name;
        logic [63:0] va;
        logic [63:0] vb;
        logic        add;
        logic [63:0] exp_diff;
        logic        exp_borrow;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  diff;
    logic          borrow;
    logic          zero;
    logic          overflow;
`ifdef SERIAL_SUB_ADD_EN
    logic          add_in;
`endif

    int            checks;
    int            failures;
    int            bad;
    logic [63:0]   last_diff;
    vec_t          vecs[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef SERIAL_SUB_ADD_EN
        .add      (add_in),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Presents operands with start just before edge E0 and returns right after E0.
    task automatic apply_stimulus(input logic [63:0] va, input logic [63:0] vb);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Walks cycles 0..W+1 after E0: busy window, held outputs, done pulse and result flags.
    task automatic check_output(input string name, input logic [63:0] ed, input logic eb,
                                input logic ez, input logic eo);
        int bad_busy = 0;
        int bad_hold = 0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            if (diff !== last_diff) bad_hold++;
        end
        check_value({name, "_busy_window"}, 64'(bad_busy), 64'd0);
        check_value({name, "_hold"}, 64'(bad_hold), 64'd0);
        @(negedge clk);
        check_value({name, "_done"}, {62'd0, done, busy}, 64'd2);
        check_value({name, "_diff"}, diff, ed);
        check_value({name, "_flags"}, {61'd0, borrow, zero, overflow}, {61'd0, eb, ez, eo});
        @(negedge clk);
        check_value({name, "_done_drop"}, {62'd0, done, busy}, 64'd0);
        last_diff = ed;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_diff = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
`ifdef SERIAL_SUB_ADD_EN
        add_in    = 1'b0;
`endif

        vecs.push_back('{"sub_5_3", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_3_5", 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                         64'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_min_1", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                         64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_0_1", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_max_neg1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                         64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1});
`ifdef SERIAL_SUB_ADD_EN
        vecs.push_back('{"add_neg1_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"add_max_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
                         64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"add0_sub_3_5", 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0});
`endif

        repeat (2) @(negedge clk);
        check_value("reset_state", {diff[59:0], busy, done, borrow, zero | overflow}, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
`ifdef SERIAL_SUB_ADD_EN
            add_in = vecs[i].add;
`endif
            apply_stimulus(vecs[i].va, vecs[i].vb);
            check_output(vecs[i].name, vecs[i].exp_diff, vecs[i].exp_borrow,
                         vecs[i].exp_zero, vecs[i].exp_ovf);
        end
`ifdef SERIAL_SUB_ADD_EN
        add_in = 1'b0;
`endif

        // A start pulse mid-run must not disturb the operation or re-sample operands.
        apply_stimulus(64'd10, 64'd4);
        bad = 0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 20) begin
                a     = 64'd1;
                b     = 64'd9;
                start = 1'b1;
            end
            if (k == 21) start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        check_value("ignored_start_busy", 64'(bad), 64'd0);
        @(negedge clk);
        check_value("ignored_start_done", {63'd0, done}, 64'd1);
        check_value("ignored_start_diff", diff, 64'd6);

        // Start held high: ignored in DONE, accepted from IDLE one cycle later.
        a     = 64'd5;
        b     = 64'd20;
        start = 1'b1;
        @(negedge clk);
        check_value("b2b_idle_gap", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        check_value("b2b_accept_busy", {63'd0, busy}, 64'd1);
        repeat (W - 1) @(negedge clk);
        @(negedge clk);
        check_value("b2b_done", {62'd0, done, busy}, 64'd2);
        check_value("b2b_diff", diff, 64'hFFFF_FFFF_FFFF_FFF1);
        check_value("b2b_borrow", {63'd0, borrow}, 64'd1);
        @(negedge clk);
        check_value("b2b_idle_gap2", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check_value("b2b_second_accept", {63'd0, busy}, 64'd1);

        // Asynchronous reset in cycle 30 of the third operation.
        repeat (30) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("midrun_reset_diff", diff, 64'd0);
        check_value("midrun_reset_ctrl", {59'd0, busy, done, borrow, zero, overflow}, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_diff = '0;
        apply_stimulus(64'd7, 64'd7);
        check_output("after_reset_7_7", 64'd0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
